// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - TMDS symbol classes, fixed tokens, TERC4 table (TMDS_TERC4_EN) and popcount
package tmds_pkg;

  typedef enum logic [1:0] {
    MODE_VIDEO   = 2'd0,
    MODE_VID_GB  = 2'd1,
    MODE_DATA    = 2'd2,
    MODE_DATA_GB = 2'd3
  } mode_e;

  localparam logic [9:0] CTL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTL_TOKEN_11 = 10'b1010101011;

  // Video guard band: channels 0 and 2 share pattern A, channel 1 uses B
  localparam logic [9:0] VID_GB_A = 10'b1011001100;
  localparam logic [9:0] VID_GB_B = 10'b0100110011;
  localparam logic [9:0] DATA_GB  = 10'b0100110011;

  function automatic logic [9:0] ctl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = CTL_TOKEN_00;
      2'b01:   t = CTL_TOKEN_01;
      2'b10:   t = CTL_TOKEN_10;
      default: t = CTL_TOKEN_11;
    endcase
    return t;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

`ifdef TMDS_TERC4_EN
  function automatic logic [9:0] terc4(input logic [3:0] nib);
    logic [9:0] t;
    case (nib)
      4'h0:    t = 10'b1010011100;
      4'h1:    t = 10'b1001100011;
      4'h2:    t = 10'b1011100100;
      4'h3:    t = 10'b1011100010;
      4'h4:    t = 10'b0101110001;
      4'h5:    t = 10'b0100011110;
      4'h6:    t = 10'b0110001110;
      4'h7:    t = 10'b0100111100;
      4'h8:    t = 10'b1011001100;
      4'h9:    t = 10'b0100111001;
      4'hA:    t = 10'b0110011100;
      4'hB:    t = 10'b1011000110;
      4'hC:    t = 10'b1010001110;
      4'hD:    t = 10'b1001110001;
      4'hE:    t = 10'b0101100011;
      default: t = 10'b1011000011;
    endcase
    return t;
  endfunction
`endif

endpackage

// File: rtl/tmds_ch_enc.sv
// rtl/tmds_ch_enc.sv - one TMDS lane: transition minimisation, DC balance, fixed tokens (TMDS_TERC4_EN)
module tmds_ch_enc
  import tmds_pkg::*;
#(
  parameter int unsigned ROLE = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [1:0] mode_i,
  input  logic       de_i,
  input  logic [1:0] ctl_i,
  input  logic [3:0] aux_i,
  input  logic [7:0] data_i,
  output logic       valid_o,
  output logic [9:0] sym_o
);

  logic [3:0]        d_ones;
  logic              use_xnor;
  logic [8:0]        qm_d;
  logic              video_d;
  logic [9:0]        tok_d;
  mode_e             mode_sel;

  logic              s1_valid_q;
  logic [8:0]        qm_q;
  logic              video_q;
  logic [9:0]        tok_q;

  logic [3:0]        qm_ones;
  logic signed [4:0] bal;
  logic [9:0]        sym_d;
  logic signed [4:0] cnt_d;

  logic              valid_q;
  logic [9:0]        sym_q;
  logic signed [4:0] cnt_q;

`ifndef TMDS_TERC4_EN
  logic unused_aux;
  assign unused_aux = ^aux_i;
`endif

  // Stage 1: transition-minimising XOR/XNOR chain
  always_comb begin
    d_ones   = popcount8(data_i);
    use_xnor = (d_ones > 4'd4) || ((d_ones == 4'd4) && !data_i[0]);
    qm_d     = '0;
    qm_d[0]  = data_i[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ data_i[i]) : (qm_d[i-1] ^ data_i[i]);
    end
    qm_d[8] = ~use_xnor;
  end

  // Stage 1: classify the symbol and preselect the fixed token for this lane
  always_comb begin
    mode_sel = mode_e'(mode_i);
`ifndef TMDS_TERC4_EN
    if (mode_sel != MODE_VID_GB) mode_sel = MODE_VIDEO;
`endif
    video_d = 1'b0;
    tok_d   = ctl_token(ctl_i);
    case (mode_sel)
      MODE_VID_GB:  tok_d = (ROLE == 1) ? VID_GB_B : VID_GB_A;
`ifdef TMDS_TERC4_EN
      MODE_DATA:    tok_d = terc4(aux_i);
      MODE_DATA_GB: tok_d = (ROLE == 0) ? terc4({2'b11, ctl_i}) : DATA_GB;
`endif
      default:      video_d = de_i;
    endcase
  end

  // Stage 1 registers; always advance, the valid bit qualifies the slot
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      qm_q       <= '0;
      video_q    <= 1'b0;
      tok_q      <= CTL_TOKEN_00;
    end else begin
      s1_valid_q <= valid_i;
      qm_q       <= qm_d;
      video_q    <= video_d;
      tok_q      <= tok_d;
    end
  end

  // Stage 2: DC balancing against the running disparity, fixed tokens reset it
  always_comb begin
    qm_ones = popcount8(qm_q[7:0]);
    bal     = $signed({qm_ones, 1'b0}) - 5'sd8;
    sym_d   = tok_q;
    cnt_d   = 5'sd0;
    if (video_q) begin
      if ((cnt_q == 5'sd0) || (bal == 5'sd0)) begin
        sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
        cnt_d = qm_q[8] ? (cnt_q + bal) : (cnt_q - bal);
      end else if (((cnt_q > 5'sd0) && (bal > 5'sd0)) || ((cnt_q < 5'sd0) && (bal < 5'sd0))) begin
        sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
        cnt_d = cnt_q - bal + (qm_q[8] ? 5'sd2 : 5'sd0);
      end else begin
        sym_d = {1'b0, qm_q[8], qm_q[7:0]};
        cnt_d = cnt_q + bal - (qm_q[8] ? 5'sd0 : 5'sd2);
      end
    end
  end

  // Stage 2 registers; empty slots hold symbol and disparity
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      sym_q   <= CTL_TOKEN_00;
      cnt_q   <= 5'sd0;
    end else begin
      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sym_q <= sym_d;
        cnt_q <= cnt_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign sym_o   = sym_q;

endmodule

// File: rtl/tmds_enc_multi.sv
// rtl/tmds_enc_multi.sv - NUM_CH-lane pipelined TMDS encoder, TERC4 data islands under TMDS_TERC4_EN
module tmds_enc_multi
  import tmds_pkg::*;
#(
  parameter int unsigned NUM_CH = 3
) (
  input  logic                   clk_1x,
  input  logic                   sys_rst,
  input  logic                   in_valid,
  input  logic [1:0]             mode,
  input  logic                   de,
  input  logic                   hsync,
  input  logic                   vsync,
  input  logic [3:0]             ctl,
  input  logic [NUM_CH*8-1:0]    vid_data,
  input  logic [NUM_CH*4-1:0]    aux_data,
  output logic                   out_valid,
  output logic [NUM_CH*10-1:0]   tmds_q
);

  logic [NUM_CH-1:0] ch_valid;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [1:0] ctl_bits;

    // Lanes repeat the channel 0/1/2 roles for control bit and guard band selection
    if (k % 3 == 0) begin : g_role0
      assign ctl_bits = {vsync, hsync};
    end else if (k % 3 == 1) begin : g_role1
      assign ctl_bits = ctl[1:0];
    end else begin : g_role2
      assign ctl_bits = ctl[3:2];
    end

    tmds_ch_enc #(
      .ROLE(k % 3)
    ) u_enc (
      .clk_i   (clk_1x),
      .rst_i   (sys_rst),
      .valid_i (in_valid),
      .mode_i  (mode),
      .de_i    (de),
      .ctl_i   (ctl_bits),
      .aux_i   (aux_data[4*k +: 4]),
      .data_i  (vid_data[8*k +: 8]),
      .valid_o (ch_valid[k]),
      .sym_o   (tmds_q[10*k +: 10])
    );
  end

  // Every lane advances in lockstep, so their valids are identical
  assign out_valid = &ch_valid;

endmodule

// File: tb/tb_tmds_enc_multi.sv
// tb/tb_tmds_enc_multi.sv - scoreboard bench for tmds_enc_multi (3 lanes)
module tb_tmds_enc_multi;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] GBA = 10'b1011001100;
  localparam logic [9:0] GBB = 10'b0100110011;
  localparam logic [9:0] F8A = 10'b1011111101;
  localparam logic [9:0] F8B = 10'b0000000010;
  localparam logic [29:0] RST3 = {C00, C00, C00};
`ifdef TMDS_TERC4_EN
  localparam logic [9:0] T4 [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
`endif

  logic        clk_1x = 1'b0;
  logic        sys_rst;
  logic        in_valid;
  logic [1:0]  mode;
  logic        de, hsync, vsync;
  logic [3:0]  ctl;
  logic [23:0] vid_data;
  logic [11:0] aux_data;
  logic        out_valid;
  logic [29:0] tmds_q;

  int          checks = 0;
  int          errors = 0;
  logic [29:0] sb[$];
  int          ref_cnt[3];
  logic        mon_en = 1'b0;
  logic [29:0] last_q;
  int          low_run = 0;
  int          last_gap = 0;

  tmds_enc_multi #(.NUM_CH(3)) dut (
    .clk_1x    (clk_1x),
    .sys_rst   (sys_rst),
    .in_valid  (in_valid),
    .mode      (mode),
    .de        (de),
    .hsync     (hsync),
    .vsync     (vsync),
    .ctl       (ctl),
    .vid_data  (vid_data),
    .aux_data  (aux_data),
    .out_valid (out_valid),
    .tmds_q    (tmds_q)
  );

  always #5 clk_1x = ~clk_1x;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_1x);
    #1;
  endtask

  task automatic ref_video(input logic [7:0] d, input int cin, output logic [9:0] q, output int cout);
    int n1, a, b;
    logic xn;
    logic [8:0] qm;
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~xn;
    a = $countones(qm[7:0]);
    b = 8 - a;
    if (cin == 0 || a == b) begin
      q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cout = cin + (qm[8] ? (a - b) : (b - a));
    end else if ((cin > 0 && a > b) || (cin < 0 && b > a)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      cout = cin + (qm[8] ? 2 : 0) + b - a;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      cout = cin + a - b - (qm[8] ? 0 : 2);
    end
  endtask

  task automatic send(input logic [1:0] m, input logic d_en, input logic hs, input logic vs,
                      input logic [3:0] c, input logic [23:0] vid, input logic [11:0] aux,
                      input logic use_lit, input logic [29:0] lit);
    logic [29:0] exp;
    logic [9:0]  q;
    logic [1:0]  cb, em;
    int          nc;
    for (int k = 0; k < 3; k++) begin
      cb = (k == 0) ? {vs, hs} : (k == 1) ? c[1:0] : c[3:2];
`ifdef TMDS_TERC4_EN
      em = m;
`else
      em = (m == 2'd1) ? 2'd1 : 2'd0;
`endif
      q = '0;
      ref_cnt[k] = (em == 2'd0 && d_en) ? ref_cnt[k] : 0;
      case (em)
        2'd0: begin
          if (d_en) begin
            ref_video(vid[8*k +: 8], ref_cnt[k], q, nc);
            ref_cnt[k] = nc;
          end else begin
            case (cb)
              2'b00:   q = C00;
              2'b01:   q = C01;
              2'b10:   q = C10;
              default: q = C11;
            endcase
          end
        end
        2'd1: q = (k == 1) ? GBB : GBA;
`ifdef TMDS_TERC4_EN
        2'd2: q = T4[aux[4*k +: 4]];
        2'd3: q = (k == 0) ? T4[{2'b11, cb}] : GBB;
`endif
        default: q = '0;
      endcase
      exp[10*k +: 10] = q;
    end
    sb.push_back(use_lit ? lit : exp);
    in_valid = 1'b1; mode = m; de = d_en; hsync = hs; vsync = vs;
    ctl = c; vid_data = vid; aux_data = aux;
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    mode = 2'($urandom_range(0, 3));
    de = 1'($urandom_range(0, 1));
    vid_data = 24'($urandom);
    step();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  // Output side of the scoreboard plus hold checks on empty slots
  always @(negedge clk_1x) begin
    if (mon_en) begin
      if (out_valid) begin
        if (low_run > 0) last_gap = low_run;
        low_run = 0;
        if (sb.size() == 0) check("sb_underflow", 32'(sb.size()), 32'd1);
        else check("tmds", {2'b00, tmds_q}, {2'b00, sb.pop_front()});
        last_q = tmds_q;
      end else begin
        low_run++;
        check("hold", {2'b00, tmds_q}, {2'b00, last_q});
      end
    end
    if (sys_rst) begin
      sb.delete();
      last_q = RST3;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    sys_rst = 1'b1; in_valid = 1'b0; mode = 2'd0; de = 1'b0; hsync = 1'b0; vsync = 1'b0;
    ctl = 4'd0; vid_data = '0; aux_data = '0;
    for (int k = 0; k < 3; k++) ref_cnt[k] = 0;
    repeat (3) step();
    @(negedge clk_1x);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_tmds", {2'b00, tmds_q}, {2'b00, RST3});
    sys_rst = 1'b0;
    last_q = RST3;
    mon_en = 1'b1;

    // Continuous F8 video from reset
    send(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 24'hF8F8F8, 12'h0, 1'b1, {F8A, F8A, F8A});
    send(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 24'hF8F8F8, 12'h0, 1'b1, {F8B, F8B, F8B});
    send(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 24'hF8F8F8, 12'h0, 1'b1, {F8A, F8A, F8A});
    send(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 24'hF8F8F8, 12'h0, 1'b1, {F8B, F8B, F8B});
    // Control tokens then video restarting from zero disparity
    send(2'd0, 1'b0, 1'b1, 1'b0, 4'b1000, 24'h0, 12'h0, 1'b1, {C10, C00, C01});
    send(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 24'hF8F8F8, 12'h0, 1'b1, {F8A, F8A, F8A});
    send(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 24'hF8F8F8, 12'h0, 1'b1, {F8B, F8B, F8B});
    // Video guard band with a one-cycle bubble
    last_gap = 0;
    send(2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 24'h123456, 12'h0, 1'b1, {GBA, GBB, GBA});
    idle();
    send(2'd1, 1'b0, 1'b1, 1'b1, 4'hF, 24'h0, 12'h0, 1'b1, {GBA, GBB, GBA});
    drain();
    check("bubble_gap", 32'(last_gap), 32'd1);

`ifdef TMDS_TERC4_EN
    send(2'd2, 1'b1, 1'b0, 1'b0, 4'd0, 24'h0, 12'hF05, 1'b1, {T4[15], T4[0], 10'b0100011110});
    send(2'd3, 1'b1, 1'b0, 1'b1, 4'd0, 24'h0, 12'h0, 1'b1, {GBB, GBB, 10'b0101100011});
`else
    send(2'd2, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 12'hF05, 1'b1, RST3);
    send(2'd3, 1'b0, 1'b1, 1'b1, 4'd0, 24'h0, 12'h0, 1'b1, {C00, C00, C11});
`endif

    // Random mixed traffic against the reference model
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 7) == 0) idle();
      else send(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 4'($urandom), 24'($urandom), 12'($urandom), 1'b0, '0);
    end

    // Mid-stream reset after the second F8 symbol
    send(2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0, 12'h0, 1'b0, '0);
    send(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 24'hF8F8F8, 12'h0, 1'b1, {F8A, F8A, F8A});
    send(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 24'hF8F8F8, 12'h0, 1'b1, {F8B, F8B, F8B});
    sys_rst = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) ref_cnt[k] = 0;
    step();
    sys_rst = 1'b0;
    @(negedge clk_1x);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_tmds", {2'b00, tmds_q}, {2'b00, RST3});
    send(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 24'hF8F8F8, 12'h0, 1'b1, {F8A, F8A, F8A});
    send(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 24'hF8F8F8, 12'h0, 1'b1, {F8B, F8B, F8B});
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_enc_multi.md
# tmds_enc_multi

Parametrised, pipelined TMDS symbol encoder for NUM_CH channels with per-channel running disparity. It supports four symbol classes: video data, control tokens, guard bands and, optionally, TERC4 data-island symbols. It sits between the video timing/pixel source and the 10:1 serialisers of the HDMI transmit path, entirely in the pixel clock domain. It succeeds the fixed three-channel, video-only encoder.

## Interface
- NUM_CH, 3, number of TMDS channels (≥3). Channel k uses the channel-(k mod 3) rules for control and guard-band selection.
- clk_1x  in  1  pixel clock
- sys_rst  in  1  synchronous, active-high reset
- in_valid  in  1  input symbol qualifier
- mode  in  2  symbol class: 0 video/control (selected by de), 1 video guard band, 2 data island (TERC4), 3 data-island guard band
- de  in  1  data enable: 1 selects video, 0 selects control (mode 0 only)
- hsync, vsync  in  1 each  control bits for channel 0
- ctl  in  4  CTL3..0; channel 1 gets {ctl[1],ctl[0]}, channel 2 gets {ctl[3],ctl[2]}
- vid_data  in  NUM_CH*8  pixel byte for channel k at [8k+7:8k]
- aux_data  in  NUM_CH*4  TERC4 nibble for channel k at [4k+3:4k]
- out_valid  out  1  in_valid delayed by 2 cycles
- tmds_q  out  NUM_CH*10  10-bit symbol for channel k at [10k+9:10k]; bit 0 is transmitted first

## Operation
- Stage 1, per channel:
  - n1 = popcount(D).
  - If n1>4, or n1==4 and D[0]==0: XNOR chain, q_m[0]=D[0], q_m[i]=~(q_m[i-1]^D[i]), q_m[8]=0.
  - Otherwise: XOR chain, q_m[8]=1.
  - Register q_m, the symbol class and the preselected fixed token.
- Stage 2, video symbols, with N1/N0 = ones/zeros of q_m[7:0] and cnt a signed 5-bit per-channel disparity:
  - cnt==0 or N1==N0: q={~q_m8, q_m8, q_m8 ? q_m : ~q_m}; cnt += q_m8 ? N1-N0 : N0-N1.
  - (cnt>0 and N1>N0) or (cnt<0 and N0>N1): q={1, q_m8, ~q_m}; cnt += 2·q_m8 + N0-N1.
  - Otherwise: q={0, q_m8, q_m}; cnt += N1-N0 − 2·~q_m8.
- Control tokens, by {c1,c0}:
  - 00 → 1101010100
  - 01 → 0010101011
  - 10 → 0101010100
  - 11 → 1010101011
  - Channel 0 uses c0=hsync, c1=vsync.
- Video guard band: ch0 1011001100, ch1 0100110011, ch2 1011001100.
- Data-island guard band: ch1 and ch2 0100110011; ch0 TERC4({1,1,vsync,hsync}).
- Any non-video symbol forces cnt=0.

## Timing
- Latency is exactly 2 cycles from in_valid/data to tmds_q/out_valid. The pipeline always advances.
- A stage-2 slot with valid=0 holds tmds_q and cnt unchanged.
- Reset values: tmds_q = 1101010100 on every channel, out_valid=0, all cnt=0, stage-1 valid=0.
- sys_rst asserted mid-stream flushes both stages in the same edge. The first post-reset video symbol encodes from cnt=0.
- mode and de are sampled only with in_valid=1. Mode changes take effect on the next symbol, and no bubble is inserted.
- Disparity is encoded as 5-bit signed two's complement. The reachable range is −8..+8, so it never wraps.

## Configuration
- TMDS_TERC4_EN defined:
  - mode 2 outputs TERC4(aux nibble) on every channel, using the table 0:1010011100 1:1001100011 2:1011100100 3:1011100010 4:0101110001 5:0100011110 6:0110001110 7:0100111100 8:1011001100 9:0100111001 A:0110011100 B:1011000110 C:1010001110 D:1001110001 E:0101100011 F:1011000011.
  - mode 3 outputs the data-island guard band.
- TMDS_TERC4_EN undefined: modes 2 and 3 behave exactly as mode 0, the TERC4 table is not synthesised, and aux_data is ignored.

## Structure
- Package tmds_pkg: mode enum, control-token constants, guard-band constants, TERC4 table, and a popcount function.
- Sub-module tmds_ch_enc: one channel (both stages plus cnt), instantiated NUM_CH times by a generate loop. The top level only slices buses and maps the control bits for each channel.

## Test plan
- Reset: hold sys_rst for 3 cycles → every channel outputs 1101010100 and out_valid=0.
- Video: mode=0, de=1, vid_data=F8 on all channels, continuous from reset → tmds_q sequence starting 2 cycles later is 1011111101, 0000000010, 1011111101, 0000000010, with cnt progressing 6, −2, 4, −4.
- Control: de=0, hsync=1, vsync=0, ctl=4'b1000 → ch0 0010101011, ch1 1101010100, ch2 0101010100. The next video symbol F8 outputs 1011111101 because cnt=0.
- Guard band and bubble: mode=1 → ch0/1/2 = 1011001100 / 0100110011 / 1011001100. Dropping in_valid for 1 cycle → tmds_q holds its value and out_valid=0 for exactly 1 cycle.
- TERC4 (TMDS_TERC4_EN defined): mode=2, aux ch0=5 → 0100011110. Without the macro, the same stimulus with de=0, hsync=0, vsync=0 → 1101010100.
- Mid-stream reset: pulse sys_rst for 1 cycle after the second F8 symbol → out_valid=0 next cycle, and restarted F8 video outputs 1011111101 first.
